// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and single-cycle access sequencer for the data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (requester 0 wins).
module dmem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_wdata0,
    output logic              o_ack0,
    output logic [DATA_W-1:0] o_rdata0,
    input  logic              i_req1,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata1,
    output logic              o_mem_en,
    output logic              o_mem_wen,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy,
    output logic              o_owner
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_ACK
    } state_t;

    state_t            r_state;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic w_any_req;
    logic w_winner;
    logic w_access;
    logic w_ack;

    assign w_any_req = i_req0 | i_req1;

`ifdef DMEM_ARB_RR_EN
    logic r_ptr;

    // A lone requester wins outright; the pointer only breaks ties.
    assign w_winner = (i_req0 & i_req1) ? r_ptr : i_req1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_ptr <= ~w_winner;
        end
    end
`else
    assign w_winner = ~i_req0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state <= S_ACCESS;
                        r_owner <= w_winner;
                        r_we    <= w_winner ? i_we1    : i_we0;
                        r_addr  <= w_winner ? i_addr1  : i_addr0;
                        r_wdata <= w_winner ? i_wdata1 : i_wdata0;
                    end
                end
                S_ACCESS: begin
                    r_state <= S_ACK;
                    r_rdata <= i_mem_rdata;
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from registered state, so an async reset clears them at once.
    assign w_access    = (r_state == S_ACCESS);
    assign w_ack       = (r_state == S_ACK);

    assign o_mem_en    = w_access;
    assign o_mem_wen   = w_access & r_we;
    assign o_mem_addr  = w_access ? r_addr  : '0;
    assign o_mem_wdata = w_access ? r_wdata : '0;

    assign o_ack0      = w_ack & ~r_owner;
    assign o_ack1      = w_ack &  r_owner;
    assign o_rdata0    = o_ack0 ? r_rdata : '0;
    assign o_rdata1    = o_ack1 ? r_rdata : '0;

    assign o_busy      = (r_state != S_IDLE);
    assign o_owner     = r_owner;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 16x8 memory attached.
module tb_dmem_arbiter;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_req0, i_we0, i_req1, i_we1;
    logic [3:0] i_addr0, i_addr1;
    logic [7:0] i_wdata0, i_wdata1;
    logic       o_ack0, o_ack1;
    logic [7:0] o_rdata0, o_rdata1;
    logic       o_mem_en, o_mem_wen;
    logic [3:0] o_mem_addr;
    logic [7:0] o_mem_wdata;
    logic [7:0] i_mem_rdata;
    logic       o_busy, o_owner;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [16] = '{default: 8'h00};

    dmem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req0     (i_req0),
        .i_we0      (i_we0),
        .i_addr0    (i_addr0),
        .i_wdata0   (i_wdata0),
        .o_ack0     (o_ack0),
        .o_rdata0   (o_rdata0),
        .i_req1     (i_req1),
        .i_we1      (i_we1),
        .i_addr1    (i_addr1),
        .i_wdata1   (i_wdata1),
        .o_ack1     (o_ack1),
        .o_rdata1   (o_rdata1),
        .o_mem_en   (o_mem_en),
        .o_mem_wen  (o_mem_wen),
        .o_mem_addr (o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata),
        .o_busy     (o_busy),
        .o_owner    (o_owner)
    );

    initial forever #5 i_clk = ~i_clk;

    assign i_mem_rdata = mem[o_mem_addr];
    always @(posedge i_clk) begin
        if (o_mem_en && o_mem_wen) mem[o_mem_addr] <= o_mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic p, input logic req, input logic we,
                           input logic [3:0] a, input logic [7:0] d);
        if (!p) begin
            i_req0 = req; i_we0 = we; i_addr0 = a; i_wdata0 = d;
        end else begin
            i_req1 = req; i_we1 = we; i_addr1 = a; i_wdata1 = d;
        end
    endtask

    // Entered at a falling edge with the DUT idle; leaves at the falling edge of the next idle cycle.
    task automatic txn(input string tag, input logic p, input logic we,
                       input logic [3:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
        check({tag, ".idle_busy"}, 32'(o_busy), 0);
        set_req(p, 1'b1, we, a, d);
        @(negedge i_clk);
        check({tag, ".mem_en"},    32'(o_mem_en), 1);
        check({tag, ".mem_wen"},   32'(o_mem_wen), 32'(we));
        check({tag, ".mem_addr"},  32'(o_mem_addr), 32'(a));
        check({tag, ".mem_wdata"}, 32'(o_mem_wdata), 32'(d));
        check({tag, ".acc_busy"},  32'(o_busy), 1);
        check({tag, ".owner"},     32'(o_owner), 32'(p));
        check({tag, ".acc_acks"},  32'({o_ack1, o_ack0}), 0);
        @(negedge i_clk);
        check({tag, ".ack_mem_en"}, 32'(o_mem_en), 0);
        check({tag, ".acks"},       32'({o_ack1, o_ack0}), p ? 2 : 1);
        check({tag, ".rdata"},      32'(p ? o_rdata1 : o_rdata0), 32'(exp_rd));
        check({tag, ".rdata_other"}, 32'(p ? o_rdata0 : o_rdata1), 0);
        check({tag, ".ack_busy"},   32'(o_busy), 1);
        set_req(p, 1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge i_clk);
        check({tag, ".end_busy"}, 32'(o_busy), 0);
        check({tag, ".end_acks"}, 32'({o_ack1, o_ack0}), 0);
    endtask

    initial begin
        logic exp_o;
        i_rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge i_clk);
        check("rst.outs", 32'({o_ack0, o_ack1, o_mem_en, o_mem_wen, o_busy, o_owner}), 0);
        check("rst.data", 32'({o_rdata0, o_rdata1, o_mem_wdata}), 0);
        check("rst.addr", 32'(o_mem_addr), 0);
        i_rst = 1'b0;

        txn("w0_a5",  1'b0, 1'b1, 4'h3, 8'hA5, 8'h00);
        txn("r1_a5",  1'b1, 1'b0, 4'h3, 8'h00, 8'hA5);
        txn("w0_22",  1'b0, 1'b1, 4'h2, 8'h22, 8'h00);
        txn("w1_77",  1'b1, 1'b1, 4'h7, 8'h77, 8'h00);
        txn("w1_19",  1'b1, 1'b1, 4'h9, 8'h19, 8'h00);

        // Both requesters hold their requests through four grants.
        set_req(1'b0, 1'b1, 1'b0, 4'h3, 8'h00);
        set_req(1'b1, 1'b1, 1'b0, 4'h7, 8'h00);
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
            exp_o = k[0];
`else
            exp_o = 1'b0;
`endif
            @(negedge i_clk);
            check($sformatf("arb%0d.owner", k), 32'(o_owner), 32'(exp_o));
            @(negedge i_clk);
            check($sformatf("arb%0d.acks", k), 32'({o_ack1, o_ack0}), exp_o ? 2 : 1);
            check($sformatf("arb%0d.rdata", k), 32'(exp_o ? o_rdata1 : o_rdata0),
                  exp_o ? 32'h77 : 32'hA5);
            @(negedge i_clk);
            check($sformatf("arb%0d.busy", k), 32'(o_busy), 0);
        end
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);

        // Address changes during ACCESS must not reach the memory.
        set_req(1'b0, 1'b1, 1'b0, 4'h2, 8'h00);
        @(negedge i_clk);
        i_addr0 = 4'h7;
        #1;
        check("hold.mem_addr", 32'(o_mem_addr), 32'h2);
        @(negedge i_clk);
        check("hold.rdata", 32'(o_rdata0), 32'h22);
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge i_clk);

        // Reset mid-ACCESS aborts the write and restores the pointer.
        set_req(1'b0, 1'b1, 1'b1, 4'h9, 8'h5A);
        @(negedge i_clk);
        check("rsta.mem_en_before", 32'(o_mem_en), 1);
        #1 i_rst = 1'b1;
        #1;
        check("rsta.mem_en", 32'(o_mem_en), 0);
        check("rsta.busy",   32'(o_busy), 0);
        check("rsta.owner",  32'(o_owner), 0);
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge i_clk);
        i_rst = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 4'h9, 8'h00);
        set_req(1'b1, 1'b1, 1'b0, 4'h9, 8'h00);
        @(negedge i_clk);
        check("rsta.ptr_owner", 32'(o_owner), 0);
        @(negedge i_clk);
        check("rsta.ack0", 32'({o_ack1, o_ack0}), 1);
        check("rsta.old_data", 32'(o_rdata0), 32'h19);
        set_req(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge i_clk);
        check("pend.idle_busy", 32'(o_busy), 0);
        @(negedge i_clk);
        check("pend.owner", 32'(o_owner), 1);
        @(negedge i_clk);
        check("pend.ack1", 32'({o_ack1, o_ack0}), 2);
        check("pend.rdata1", 32'(o_rdata1), 32'h19);
        set_req(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge i_clk);

        txn("w0_ff", 1'b0, 1'b1, 4'hF, 8'hFF, 8'h00);
        txn("r1_ff", 1'b1, 1'b0, 4'hF, 8'h00, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the 16-entry × 8-bit data memory. It lets two requesters share the memory's single port: requester 0 is the core load/store path and requester 1 is the debug/DMA loader. The block captures one request at a time, drives the memory enable, write-enable, address and write-data lines for exactly one cycle, registers the read data, and returns a one-cycle acknowledge to the winning requester.

## Interface
Parameters:
- ADDR_W, 4, address width; must match the data-memory depth (2^ADDR_W entries)
- DATA_W, 8, data width

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  reset; asynchronous, active-high
- i_req0  in  1  requester 0 request; held high until o_ack0
- i_we0  in  1  requester 0 operation; 1 = write, 0 = read
- i_addr0  in  ADDR_W  requester 0 address
- i_wdata0  in  DATA_W  requester 0 write data
- o_ack0  out  1  requester 0 acknowledge; one-cycle pulse
- o_rdata0  out  DATA_W  requester 0 read data; valid while o_ack0 is high
- i_req1, i_we1, i_addr1, i_wdata1, o_ack1, o_rdata1: same as requester 0, for requester 1
- o_mem_en  out  1  drives the memory enable
- o_mem_wen  out  1  drives the memory write enable
- o_mem_addr  out  ADDR_W  drives the memory address
- o_mem_wdata  out  DATA_W  drives the memory write data
- i_mem_rdata  in  DATA_W  combinational read data from the memory
- o_busy  out  1  high in every state except IDLE
- o_owner  out  1  index of the requester currently granted; holds its value in IDLE

## Operation
- FSM states: IDLE, ACCESS, ACK.
- IDLE → ACCESS when any request is high at the clock edge. On that edge:
  - choose the winner;
  - latch its we, addr and wdata into internal registers;
  - set o_owner to the winner.
- ACCESS → ACK unconditionally. During ACCESS:
  - o_mem_en = 1;
  - o_mem_wen = latched we;
  - o_mem_addr and o_mem_wdata = latched values.
  - The memory performs its write at the edge that ends ACCESS.
  - At that same edge, i_mem_rdata is captured into the read-data register, for both reads and writes.
- ACK → IDLE unconditionally. During ACK:
  - o_ack[owner] = 1;
  - o_rdata[owner] = captured data.
- Outside ACCESS, o_mem_en, o_mem_wen, o_mem_addr and o_mem_wdata are all 0.
- Outside ACK, both o_ack outputs are 0. Both o_rdata outputs are 0 except the owner's during ACK.
- Arbitration with DMEM_ARB_RR_EN defined (round-robin):
  - a priority pointer names the favoured requester;
  - on each grant, the pointer moves to the requester that did not win;
  - if only one requester is asking, it wins regardless of the pointer.
- Requests are sampled only in IDLE. Request-line changes during ACCESS or ACK are ignored, and the latched fields are not re-read.
- A requester deasserts req on the edge that ends its ACK cycle. If req is still high in the following IDLE cycle, it is treated as a new request.

## Timing
- Reset values:
  - state = IDLE;
  - all outputs 0, including o_owner;
  - latched fields and read-data register 0;
  - priority pointer = requester 0.
- Reset is asynchronous. Asserting it mid-ACCESS drops o_mem_en immediately, so no write occurs at the next edge. Asserting it mid-ACK drops the ack and no retry is made. The requester must re-request after reset.
- Latency: request sampled at edge N → memory access during cycle N+1 → ack during cycle N+2.
- Each transaction takes 3 cycles (IDLE, ACCESS, ACK). Back-to-back sustained throughput is one transaction per 3 cycles.
- Simultaneous requests in IDLE: exactly one is granted. The loser stays pending and is granted in the next IDLE cycle if it is still requesting.
- Read-after-write to the same address from either requester returns the new data, because the write completes before the next ACCESS.
- Addresses wrap naturally within ADDR_W bits. Address 4'hF is a legal address.

## Configuration
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin arbitration via the priority pointer, as described above.
- Undefined: fixed priority; requester 0 always wins a simultaneous request and the pointer register is not implemented. Requester 1 can starve while requester 0 keeps requesting.

## Test plan
- Reset, then req0 write addr 4'h3 data 8'hA5 → o_mem_en=1, o_mem_wen=1, o_mem_addr=3, o_mem_wdata=A5 in cycle N+1; o_ack0 pulse in cycle N+2; o_ack1 stays 0.
- req1 read addr 4'h3 after the previous write → o_rdata1=8'hA5 with o_ack1 in cycle N+2; o_mem_wen=0 during ACCESS.
- req0 and req1 both held continuously, with DMEM_ARB_RR_EN defined → grants alternate 0,1,0,1; with it undefined → grants are always 0.
- Change i_addr0 from 2 to 7 during ACCESS → memory sees address 2; ack returns data from address 2.
- Assert i_rst during ACCESS of a write of 8'h5A to addr 4'h9 → o_mem_en drops immediately; a later read of addr 9 returns the old value; o_busy=0 and pointer = requester 0.
- Write 8'hFF to addr 4'hF, then read it back → o_rdata=8'hFF; o_busy is high for exactly 2 of the 3 cycles of each transaction.
